leaf_stream_bridge: RTL and testbench
=====================================

Name: leaf_stream_bridge

Overview:
- Parametrised, multi-channel buffering bridge between the packed user-side ports of leaf_interface and the per-stream ap_vld/ap_ack ports of an HLS user kernel.
- Each inbound (interface→kernel) and outbound (kernel→interface) channel gets its own FIFO, decoupling the two handshakes.
- Adds a post-reset start sequencer for ap_start, replacing a hard-tied constant.
- Sits inside each leaf wrapper, between leaf_interface and the operator.

Parameters:
- PAYLOAD_BITS, 32, data width per channel.
- NUM_IN_PORTS, 1, inbound channel count (1..8).
- NUM_OUT_PORTS, 1, outbound channel count (1..8).
- FIFO_DEPTH_BITS, 3, log2 of per-channel FIFO depth (depth 8 by default).
- START_DELAY, 4, cycles after reset release before ap_start asserts (0..255).

Ports:
- clk_user  in  1  single clock for the whole block.
- reset  in  1  synchronous, active-high.
- dout_leaf_interface2user  in  NUM_IN_PORTS*PAYLOAD_BITS  inbound data from interface; channel i at [i*PAYLOAD_BITS +: PAYLOAD_BITS].
- vld_interface2user  in  NUM_IN_PORTS  inbound valid per channel.
- ack_user2interface  out  NUM_IN_PORTS  inbound accept per channel.
- user_in_data  out  NUM_IN_PORTS*PAYLOAD_BITS  data to kernel Input_i.
- user_in_vld  out  NUM_IN_PORTS  to kernel Input_i_ap_vld.
- user_in_ack  in  NUM_IN_PORTS  from kernel Input_i_ap_ack.
- user_out_data  in  NUM_OUT_PORTS*PAYLOAD_BITS  from kernel Output_j.
- user_out_vld  in  NUM_OUT_PORTS  from kernel Output_j_ap_vld.
- user_out_ack  out  NUM_OUT_PORTS  to kernel Output_j_ap_ack.
- din_leaf_user2interface  out  NUM_OUT_PORTS*PAYLOAD_BITS  outbound data to interface.
- vld_user2interface  out  NUM_OUT_PORTS  outbound valid.
- ack_interface2user  in  NUM_OUT_PORTS  outbound accept from interface.
- ap_start  out  1  kernel start.
- xfer_count  out  (NUM_IN_PORTS+NUM_OUT_PORTS)*32  per-channel transfer counters; see Optional Feature.

Behaviour:
- Transfer rule, every handshake: a word moves on a rising edge where vld=1 and ack=1. vld must not depend combinationally on ack.
- Each channel uses one FIFO of depth 2^FIFO_DEPTH_BITS, with wr_ptr/rd_ptr of FIFO_DEPTH_BITS+1 bits. full = (MSBs differ and low bits equal). empty = (pointers equal).
- Write side ack (ack_user2interface[i] / user_out_ack[j]) = !full. It is combinational from registered pointers only.
- Read side vld (user_in_vld[i] / vld_user2interface[j]) = !empty. Data = mem[rd_ptr low bits], first-word-fall-through from registered storage.
- Latency: a word written on edge N is presented with vld=1 from cycle N+1. No same-cycle bypass.
- Full with a simultaneous read: ack is already 0, so no write that cycle. The slot is reusable on the next cycle.
- Empty with a simultaneous write: vld stays 0 this cycle and rises next cycle.
- Pointers wrap modulo 2^(FIFO_DEPTH_BITS+1). Data order is strictly FIFO per channel. Channels are fully independent.
- Start sequencer FSM, 8-bit counter cnt:
  - RESET: cnt=0, ap_start=0.
  - WAIT: cnt increments each cycle; go to RUN when cnt==START_DELAY. If START_DELAY=0, RUN is entered on the first cycle after reset deasserts.
  - RUN: ap_start=1 permanently.
- Reset values, held for every cycle reset=1 (including mid-transfer): all pointers 0, all vld outputs 0, all ack outputs 1, ap_start 0, FSM in WAIT with cnt=0, xfer_count 0.
  - Any FIFO contents are discarded on reset. Memory contents are not reset, but are never exposed while empty.
- Data outputs while vld=0 are don't-care. The bench must not check them.

Optional Feature:
- Macro LEAF_BRIDGE_XFER_COUNT_EN.
- When defined: each channel has a 32-bit wrapping counter, incremented on each write-side transfer into its FIFO.
  - Order on xfer_count: inbound channels 0..NUM_IN_PORTS-1 first, then outbound channels.
  - Counter wraps 0xFFFFFFFF→0. Cleared by reset.
- When undefined: xfer_count is tied to 0 and no counter logic is synthesised. The port list is identical in both cases.

Test Plan:
- Reset with START_DELAY=4 → ap_start=0 for the first 4 cycles after reset falls, 1 from cycle 5 on; all ack=1, all vld=0 during reset.
- Inbound channel 0: write 0x11,0x22,0x33 back-to-back with user_in_ack=1 → user_in_vld rises 1 cycle after the first write; the kernel receives 0x11,0x22,0x33 in order.
- Fill: user_in_ack=0, 8 writes (depth 8) → ack_user2interface[0]=0 after the 8th. A 9th presented word 0x99 is not accepted. Pulse user_in_ack for 1 cycle → ack returns 1 the next cycle; 0x99 is then accepted and later delivered 9th.
- NUM_OUT_PORTS=2: the kernel drives both channels while ack_interface2user=2'b01 → channel 1 fills and stalls (user_out_ack[1]=0); channel 0 flows unaffected.
- Assert reset with 5 words buffered → vld=0 next cycle. After release, a new word 0xAB is the first word delivered.
- With LEAF_BRIDGE_XFER_COUNT_EN: after 3 inbound + 2 outbound transfers, xfer_count fields read 3 and 2. Preload a counter at 0xFFFFFFFF (force) plus 1 transfer → 0. Without the macro, xfer_count stays 0.

Source files
------------

// File: rtl/leaf_stream_bridge.sv
// leaf_stream_bridge: per-channel FIFO bridge between the packed leaf_interface
// user ports and the per-stream ap_vld/ap_ack ports of an HLS kernel, plus a
// post-reset ap_start sequencer.
// Optional feature macro: LEAF_BRIDGE_XFER_COUNT_EN enables the per-channel
// 32-bit write-side transfer counters on xfer_count (tied to 0 otherwise).
// Channel numbering inside: inbound 0..NUM_IN_PORTS-1, then outbound channels.
module leaf_stream_bridge #(
  parameter int PAYLOAD_BITS    = 32,
  parameter int NUM_IN_PORTS    = 1,
  parameter int NUM_OUT_PORTS   = 1,
  parameter int FIFO_DEPTH_BITS = 3,
  parameter int START_DELAY     = 4
) (
  input  logic                                      clk_user,
  input  logic                                      reset,
  input  logic [NUM_IN_PORTS*PAYLOAD_BITS-1:0]      dout_leaf_interface2user,
  input  logic [NUM_IN_PORTS-1:0]                   vld_interface2user,
  output logic [NUM_IN_PORTS-1:0]                   ack_user2interface,
  output logic [NUM_IN_PORTS*PAYLOAD_BITS-1:0]      user_in_data,
  output logic [NUM_IN_PORTS-1:0]                   user_in_vld,
  input  logic [NUM_IN_PORTS-1:0]                   user_in_ack,
  input  logic [NUM_OUT_PORTS*PAYLOAD_BITS-1:0]     user_out_data,
  input  logic [NUM_OUT_PORTS-1:0]                  user_out_vld,
  output logic [NUM_OUT_PORTS-1:0]                  user_out_ack,
  output logic [NUM_OUT_PORTS*PAYLOAD_BITS-1:0]     din_leaf_user2interface,
  output logic [NUM_OUT_PORTS-1:0]                  vld_user2interface,
  input  logic [NUM_OUT_PORTS-1:0]                  ack_interface2user,
  output logic                                      ap_start,
  output logic [(NUM_IN_PORTS+NUM_OUT_PORTS)*32-1:0] xfer_count
);

  localparam int NCH   = NUM_IN_PORTS + NUM_OUT_PORTS;
  localparam int DEPTH = 1 << FIFO_DEPTH_BITS;
  localparam int PW    = FIFO_DEPTH_BITS + 1;

  localparam logic [1:0] ST_RESET = 2'd0;
  localparam logic [1:0] ST_WAIT  = 2'd1;
  localparam logic [1:0] ST_RUN   = 2'd2;
  localparam logic [7:0] START_CNT = 8'(START_DELAY);

  // Unified per-channel views: inbound channels in the low slots.
  logic [NCH*PAYLOAD_BITS-1:0] wr_data_all;
  logic [NCH*PAYLOAD_BITS-1:0] rd_data_all;
  logic [NCH-1:0]              wr_vld_all;
  logic [NCH-1:0]              wr_ack_all;
  logic [NCH-1:0]              rd_vld_all;
  logic [NCH-1:0]              rd_ack_all;

  assign wr_data_all = {user_out_data, dout_leaf_interface2user};
  assign wr_vld_all  = {user_out_vld, vld_interface2user};
  assign rd_ack_all  = {ack_interface2user, user_in_ack};

  assign ack_user2interface      = wr_ack_all[NUM_IN_PORTS-1:0];
  assign user_out_ack            = wr_ack_all[NCH-1:NUM_IN_PORTS];
  assign user_in_vld             = rd_vld_all[NUM_IN_PORTS-1:0];
  assign vld_user2interface      = rd_vld_all[NCH-1:NUM_IN_PORTS];
  assign user_in_data            = rd_data_all[NUM_IN_PORTS*PAYLOAD_BITS-1:0];
  assign din_leaf_user2interface = rd_data_all[NCH*PAYLOAD_BITS-1:NUM_IN_PORTS*PAYLOAD_BITS];

  // ---------------- start sequencer ----------------
  logic [1:0] state_q, state_d;
  logic [7:0] cnt_q, cnt_d;

  // Count post-reset cycles until the programmed delay, then latch RUN.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    case (state_q)
      ST_WAIT: begin
        if (cnt_q == START_CNT) state_d = ST_RUN;
        else                    cnt_d   = cnt_q + 8'd1;
      end
      ST_RUN: begin
        state_d = ST_RUN;
      end
      ST_RESET: begin
        state_d = ST_WAIT;
        cnt_d   = '0;
      end
      default: begin
        state_d = ST_WAIT;
        cnt_d   = '0;
      end
    endcase
  end

  // Sequencer state registers; reset parks the FSM in WAIT with cnt cleared.
  always_ff @(posedge clk_user) begin
    if (reset) begin
      state_q <= ST_WAIT;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end

  // ap_start rises in the same cycle the count reaches START_DELAY, so a zero
  // delay starts on the first cycle out of reset; it is held low during reset.
  assign ap_start = !reset &&
                    ((state_q == ST_RUN) || ((state_q == ST_WAIT) && (cnt_q == START_CNT)));

  // ---------------- per-channel FIFOs ----------------
  for (genvar c = 0; c < NCH; c++) begin : g_ch
    logic [PW-1:0]           wr_ptr_q, wr_ptr_d;
    logic [PW-1:0]           rd_ptr_q, rd_ptr_d;
    logic [PAYLOAD_BITS-1:0] mem_q [DEPTH];
    logic                    full, empty, do_wr, do_rd;

    // Status from registered pointers only; handshakes and pointer advance.
    always_comb begin
      full     = (wr_ptr_q[PW-1] != rd_ptr_q[PW-1]) &&
                 (wr_ptr_q[PW-2:0] == rd_ptr_q[PW-2:0]);
      empty    = (wr_ptr_q == rd_ptr_q);
      do_wr    = wr_vld_all[c] && !full;
      do_rd    = rd_ack_all[c] && !empty;
      wr_ptr_d = wr_ptr_q + PW'(do_wr);
      rd_ptr_d = rd_ptr_q + PW'(do_rd);
    end

    // Pointer registers; reset empties the FIFO by equalising the pointers.
    always_ff @(posedge clk_user) begin
      if (reset) begin
        wr_ptr_q <= '0;
        rd_ptr_q <= '0;
      end else begin
        wr_ptr_q <= wr_ptr_d;
        rd_ptr_q <= rd_ptr_d;
      end
    end

    // Storage is not reset; stale words are never visible while empty.
    always_ff @(posedge clk_user) begin
      if (do_wr) mem_q[wr_ptr_q[PW-2:0]] <= wr_data_all[c*PAYLOAD_BITS +: PAYLOAD_BITS];
    end

    assign wr_ack_all[c] = !full;
    assign rd_vld_all[c] = !empty;
    assign rd_data_all[c*PAYLOAD_BITS +: PAYLOAD_BITS] = mem_q[rd_ptr_q[PW-2:0]];

`ifdef LEAF_BRIDGE_XFER_COUNT_EN
    logic [31:0] xfer_cnt_q, xfer_cnt_d;

    // Wrapping count of words accepted on the write side.
    always_comb begin
      xfer_cnt_d = xfer_cnt_q + 32'(do_wr);
    end

    // Counter register, cleared by reset.
    always_ff @(posedge clk_user) begin
      if (reset) xfer_cnt_q <= '0;
      else       xfer_cnt_q <= xfer_cnt_d;
    end

    assign xfer_count[c*32 +: 32] = xfer_cnt_q;
`else
    assign xfer_count[c*32 +: 32] = '0;
`endif
  end

endmodule

// File: tb/tb_leaf_stream_bridge.sv
// Self-checking bench for leaf_stream_bridge (2 inbound, 2 outbound channels,
// depth 8, START_DELAY 4). A queue-per-channel model predicts ack/vld/data,
// transfer counts and ap_start every cycle; directed scenarios add literal
// expectations on the words actually delivered.
module tb_leaf_stream_bridge;
  localparam int PB  = 32;
  localparam int NI  = 2;
  localparam int NO  = 2;
  localparam int FDB = 3;
  localparam int SD  = 4;
  localparam int D   = 1 << FDB;
  localparam int NCH = NI + NO;

  logic              clk = 1'b0;
  logic              reset;
  logic [NI*PB-1:0]  din;
  logic [NI-1:0]     vin, kack;
  logic [NO*PB-1:0]  kdata;
  logic [NO-1:0]     kvld, iack;
  logic [NI-1:0]     ack_u2i, uin_vld;
  logic [NI*PB-1:0]  uin_data;
  logic [NO-1:0]     uout_ack, vout;
  logic [NO*PB-1:0]  dout;
  logic              ap_start;
  logic [NCH*32-1:0] xfer;

  leaf_stream_bridge #(
    .PAYLOAD_BITS(PB), .NUM_IN_PORTS(NI), .NUM_OUT_PORTS(NO),
    .FIFO_DEPTH_BITS(FDB), .START_DELAY(SD)
  ) dut (
    .clk_user(clk), .reset(reset),
    .dout_leaf_interface2user(din), .vld_interface2user(vin),
    .ack_user2interface(ack_u2i), .user_in_data(uin_data),
    .user_in_vld(uin_vld), .user_in_ack(kack),
    .user_out_data(kdata), .user_out_vld(kvld), .user_out_ack(uout_ack),
    .din_leaf_user2interface(dout), .vld_user2interface(vout),
    .ack_interface2user(iack), .ap_start(ap_start), .xfer_count(xfer)
  );

  always #5 clk = ~clk;

  // Channel-indexed views (inbound first, then outbound).
  logic [NCH-1:0]    w_vld, r_ack, o_wack, o_rvld;
  logic [NCH*PB-1:0] w_data, o_rdata;
  assign w_vld   = {kvld, vin};
  assign w_data  = {kdata, din};
  assign r_ack   = {iack, kack};
  assign o_wack  = {uout_ack, ack_u2i};
  assign o_rvld  = {vout, uin_vld};
  assign o_rdata = {dout, uin_data};

  int n_cmp = 0;
  int n_bad = 0;

  task automatic chk(input string nm, input int idx, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s[%0d]: got 0x%08h, required 0x%08h", nm, idx, act, exp);
    end
  endtask

  // ---------------- behavioural model ----------------
  logic [31:0] mq [NCH][$];
  logic [31:0] mcnt [NCH];
  logic [31:0] rx [NCH][$];
  int          nr = 0;
  bit          seen = 1'b0;
  bit          cnt_chk_en = 1'b1;

  initial forever begin
    @(posedge clk);
    if (reset) begin
      for (int c = 0; c < NCH; c++) begin
        mq[c].delete();
        mcnt[c] = '0;
      end
      nr   = 0;
      seen = 1'b1;
    end else if (seen) begin
      if (nr < 1000) nr++;
      for (int c = 0; c < NCH; c++) begin
        bit can_w, can_r;
        can_w = (mq[c].size() < D);
        can_r = (mq[c].size() > 0);
        if (can_r && r_ack[c]) void'(mq[c].pop_front());
        if (can_w && w_vld[c]) begin
          mq[c].push_back(w_data[c*PB +: PB]);
          mcnt[c] = mcnt[c] + 32'd1;
        end
      end
    end
  end

  // ---------------- per-cycle compare ----------------
  initial forever begin
    @(negedge clk);
    if (seen) begin
      for (int c = 0; c < NCH; c++) begin
        logic [31:0] exp_cnt;
        chk("write_ack", c, 32'(o_wack[c]), 32'(mq[c].size() < D));
        chk("read_vld", c, 32'(o_rvld[c]), 32'(mq[c].size() > 0));
        if (mq[c].size() > 0) chk("read_data", c, o_rdata[c*PB +: PB], mq[c][0]);
`ifdef LEAF_BRIDGE_XFER_COUNT_EN
        exp_cnt = mcnt[c];
`else
        exp_cnt = '0;
`endif
        if (cnt_chk_en) chk("xfer_count", c, xfer[c*32 +: 32], exp_cnt);
        if (o_rvld[c] && r_ack[c]) rx[c].push_back(o_rdata[c*PB +: PB]);
      end
      chk("ap_start", 0, 32'(ap_start), 32'(!reset && nr >= SD));
    end
  end

  function automatic logic [31:0] rx_at(input int c, input int i);
    if (i < rx[c].size()) return rx[c][i];
    return 32'hDEAD_BEEF;
  endfunction

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: got timeout, required $finish");
    $fatal(1, "watchdog");
  end

  // ---------------- stimulus ----------------
  initial begin
    int base, base1, thr;
    reset = 1'b1;
    din = '0; vin = '0; kack = '0; kdata = '0; kvld = '0; iack = '0;
    repeat (3) step();

    // Reset state: every write ack high, every read vld low, no start.
    @(negedge clk);
    chk("rst_in_ack", 0, 32'(ack_u2i), 32'h3);
    chk("rst_out_ack", 0, 32'(uout_ack), 32'h3);
    chk("rst_vld", 0, 32'({vout, uin_vld}), 32'h0);
    step();
    reset = 1'b0;
    for (int k = 1; k <= 6; k++) begin
      @(negedge clk);
      chk("ap_start_seq", k, 32'(ap_start), 32'(k >= 5));
      step();
    end

    // Three back-to-back inbound words with the kernel always accepting.
    kack[0] = 1'b1;
    base = rx[0].size();
    vin[0] = 1'b1; din[31:0] = 32'h11;
    @(negedge clk); chk("vld_before_latency", 0, 32'(uin_vld[0]), 32'h0);
    step(); din[31:0] = 32'h22;
    @(negedge clk); chk("vld_after_latency", 0, 32'(uin_vld[0]), 32'h1);
    step(); din[31:0] = 32'h33;
    step(); vin[0] = 1'b0;
    repeat (3) step();
    chk("rx_seq", 0, rx_at(0, base + 0), 32'h11);
    chk("rx_seq", 1, rx_at(0, base + 1), 32'h22);
    chk("rx_seq", 2, rx_at(0, base + 2), 32'h33);

    // Fill to depth, offer 0x99 while full, free one slot with a single ack.
    kack[0] = 1'b0;
    base = rx[0].size();
    for (int i = 1; i <= 8; i++) begin
      vin[0] = 1'b1; din[31:0] = 32'(i);
      step();
    end
    @(negedge clk); chk("full_ack", 0, 32'(ack_u2i[0]), 32'h0);
    din[31:0] = 32'h99;
    step(); step();
    kack[0] = 1'b1;
    step();
    kack[0] = 1'b0;
    @(negedge clk); chk("ack_after_pulse", 0, 32'(ack_u2i[0]), 32'h1);
    step();
    vin[0] = 1'b0; kack[0] = 1'b1;
    repeat (12) step();
    for (int i = 0; i < 8; i++) chk("fill_order", i, rx_at(0, base + i), 32'(i + 1));
    chk("ninth_word", 8, rx_at(0, base + 8), 32'h99);
    chk("fill_count", 0, 32'(rx[0].size() - base), 32'd9);

    // Outbound: channel 1 stalled by the interface, channel 0 flowing.
    iack = 2'b01; kvld = 2'b11;
    base = rx[NI].size(); base1 = rx[NI + 1].size();
    for (int i = 0; i < 12; i++) begin
      kdata = {32'hB000_0000 + 32'(i), 32'hA000_0000 + 32'(i)};
      step();
    end
    kvld = '0;
    step();
    @(negedge clk);
    chk("out1_stalled_ack", 1, 32'(uout_ack[1]), 32'h0);
    chk("out1_vld", 1, 32'(vout[1]), 32'h1);
    chk("out0_ack", 0, 32'(uout_ack[0]), 32'h1);
    step();
    chk("out0_last", 0, rx_at(NI, base + 11), 32'hA000_000B);
    chk("out1_none", 1, 32'(rx[NI + 1].size() - base1), 32'd0);
    iack = 2'b11;
    repeat (12) step();
    chk("out1_first", 1, rx_at(NI + 1, base1), 32'hB000_0000);
    chk("out1_eighth", 1, rx_at(NI + 1, base1 + 7), 32'hB000_0007);
    chk("out1_count", 1, 32'(rx[NI + 1].size() - base1), 32'd8);

    // Reset with five words buffered discards them.
    kack[0] = 1'b0;
    for (int i = 0; i < 5; i++) begin
      vin[0] = 1'b1; din[31:0] = 32'hC0 + 32'(i);
      step();
    end
    vin[0] = 1'b0; reset = 1'b1;
    step();
    @(negedge clk); chk("vld_in_reset", 0, 32'(uin_vld[0]), 32'h0);
    step();
    reset = 1'b0;
    base = rx[0].size();
    vin[0] = 1'b1; din[31:0] = 32'hAB; kack[0] = 1'b1;
    step();
    vin[0] = 1'b0;
    repeat (3) step();
    chk("post_reset_first", 0, rx_at(0, base), 32'hAB);
    chk("post_reset_count", 0, 32'(rx[0].size() - base), 32'd1);

    // Transfer counters: 3 inbound on channel 0, 2 outbound on channel 0.
    reset = 1'b1; step(); reset = 1'b0;
    kack = '1; iack = '1;
    for (int i = 0; i < 3; i++) begin
      vin[0] = 1'b1; din[31:0] = 32'h50 + 32'(i);
      kvld[0] = (i < 2); kdata[31:0] = 32'h60 + 32'(i);
      step();
    end
    vin = '0; kvld = '0;
    @(negedge clk);
`ifdef LEAF_BRIDGE_XFER_COUNT_EN
    chk("cnt_in0", 0, xfer[31:0], 32'd3);
    chk("cnt_out0", NI, xfer[NI*32 +: 32], 32'd2);
    cnt_chk_en = 1'b0;
    step();
    force dut.g_ch[0].xfer_cnt_q = 32'hFFFF_FFFF;
    step();
    release dut.g_ch[0].xfer_cnt_q;
    vin[0] = 1'b1; din[31:0] = 32'h77;
    step();
    vin[0] = 1'b0;
    @(negedge clk);
    chk("cnt_wrap", 0, xfer[31:0], 32'h0);
    step();
    reset = 1'b1; step(); reset = 1'b0;
    cnt_chk_en = 1'b1;
`else
    chk("cnt_in0_off", 0, xfer[31:0], 32'd0);
    chk("cnt_out0_off", NI, xfer[NI*32 +: 32], 32'd0);
    step();
`endif

    // Randomised traffic on all channels with varying back-pressure.
    for (int s = 0; s < 4; s++) begin
      thr = (s % 2 == 0) ? 25 : 85;
      for (int n = 0; n < 500; n++) begin
        for (int b = 0; b < NI; b++) begin
          vin[b]  = ($urandom_range(0, 99) < 60);
          kack[b] = ($urandom_range(0, 99) < thr);
        end
        for (int b = 0; b < NO; b++) begin
          kvld[b] = ($urandom_range(0, 99) < 60);
          iack[b] = ($urandom_range(0, 99) < 110 - thr);
        end
        din   = {$urandom, $urandom};
        kdata = {$urandom, $urandom};
        step();
      end
    end

    vin = '0; kvld = '0; kack = '1; iack = '1;
    repeat (12) step();
    @(negedge clk);
    chk("drained_vld", 0, 32'({vout, uin_vld}), 32'h0);
    step();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
